// File: rtl/prog_store_loader.sv
`default_nettype none
// ============================================================================
// Module : prog_store_loader
// Writable DEPTH x WIDTH program store with a CPU port and a bit-serial loader.
// Rev    : 1.0  initial release
// ============================================================================
module prog_store_loader #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter bit REVERSE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              load_valid,
  input  logic              load_bit,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [WIDTH-1:0]  cpu_wr_data,
  output logic [WIDTH-1:0]  cpu_rd_data
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_write = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(DEPTH - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [BIT_W-1:0]  r_bitcnt;
  logic [WIDTH-1:0]  r_shift;
  logic [ADDR_W:0]   r_count;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd_data;

  logic              w_write;
  logic              w_cpu_wr;
  logic              w_addr_ok;
  logic [BIT_W-1:0]  w_bit_idx;

  // Serial bit k lands in bit k (SNP order) or mirrored from the MSB.
  generate
    if (REVERSE) begin : g_bit_snp
      assign w_bit_idx = r_bitcnt;
    end else begin : g_bit_msb
      assign w_bit_idx = c_bit_last - r_bitcnt;
    end
  endgenerate

  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_part
      localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
      assign w_addr_ok = ({1'b0, cpu_addr} < c_depth);
    end
  endgenerate

  assign w_write  = (r_state == c_st_write) && !load_abort;
  assign w_cpu_wr = cpu_we && (r_state == c_st_idle) && w_addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_addr   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (load_start) begin
            r_state  <= c_st_shift;
            r_addr   <= '0;
            r_bitcnt <= '0;
            r_count  <= '0;
            r_shift  <= '0;
          end
        end
        c_st_shift: begin
          if (load_abort) begin
            r_state <= c_st_idle;
          end else if (load_valid) begin
            r_shift[w_bit_idx] <= load_bit;
            if (r_bitcnt == c_bit_last) begin
              r_bitcnt <= '0;
              r_state  <= c_st_write;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        c_st_write: begin
          if (load_abort) begin
            r_state <= c_st_idle;
          end else begin
            r_count <= r_count + 1'b1;
            if (r_addr == c_addr_last) begin
              r_state <= c_st_done;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= c_st_shift;
            end
          end
        end
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  // Read samples the old word before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_addr_ok ? r_mem[cpu_addr] : '0;
      if (w_write) begin
        r_mem[r_addr] <= r_shift;
      end else if (w_cpu_wr) begin
        r_mem[cpu_addr] <= cpu_wr_data;
      end
    end
  end

  assign load_ready  = (r_state == c_st_shift);
  assign load_busy   = (r_state != c_st_idle);
  assign load_done   = (r_state == c_st_done) && !load_abort;
  assign load_count  = r_count;
  assign cpu_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_prog_store_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_prog_store_loader
// Scoreboard bench driving one SNP-order and one MSB-first store in lockstep.
// Rev    : 1.0  initial release
// ============================================================================
module tb_prog_store_loader;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NBITS  = WIDTH * DEPTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              load_abort = 1'b0;
  logic              load_valid = 1'b0;
  logic              load_bit = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [WIDTH-1:0]  cpu_wr_data = '0;

  logic              w1_ready, w1_busy, w1_done, w0_ready, w0_busy, w0_done;
  logic [ADDR_W:0]   w1_count, w0_count;
  logic [WIDTH-1:0]  w1_rd, w0_rd;
  logic [ADDR_W+3:0] w1_st, w0_st;

  assign w1_st = {w1_busy, w1_ready, w1_done, w1_count};
  assign w0_st = {w0_busy, w0_ready, w0_done, w0_count};

  prog_store_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REVERSE(1'b1)) u_dut_snp (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
    .load_valid(load_valid), .load_bit(load_bit), .load_ready(w1_ready),
    .load_busy(w1_busy), .load_done(w1_done), .load_count(w1_count),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(w1_rd)
  );

  prog_store_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REVERSE(1'b0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
    .load_valid(load_valid), .load_bit(load_bit), .load_ready(w0_ready),
    .load_busy(w0_busy), .load_done(w0_done), .load_count(w0_count),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(w0_rd)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] img   [DEPTH];   // img[w][j] is the j-th serial bit of word w
  logic [WIDTH-1:0] m_snp [DEPTH];
  logic [WIDTH-1:0] m_msb [DEPTH];
  logic [WIDTH-1:0] q_snp [$];
  logic [WIDTH-1:0] q_msb [$];
  logic [ADDR_W+3:0] st_exp;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU cycle; the word the port should return is queued from the model.
  task automatic cpu_cycle(input int a, input bit we, input logic [WIDTH-1:0] d, input bit wr_ok);
    q_snp.push_back(m_snp[a]);
    q_msb.push_back(m_msb[a]);
    cpu_addr    = a[ADDR_W-1:0];
    cpu_we      = we;
    cpu_wr_data = d;
    tick();
    cpu_we = 1'b0;
    if (we && wr_ok) begin
      m_snp[a] = d;
      m_msb[a] = d;
    end
  endtask

  // Streams img while load_ready; stops after stop_at accepted bits (optionally aborting).
  task automatic stream_load(input int gap_pct, input int stop_at, input bit do_abort,
                             output int dc1, output int dc0);
    int ncyc;
    int accepted;
    bit rdy;
    dc1 = -1;
    dc0 = -1;
    accepted = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ncyc = 0;
    while (ncyc < 3000 && dc1 < 0) begin
      if (stop_at >= 0 && accepted == stop_at) begin
        load_valid = 1'b0;
        if (do_abort) begin
          load_abort = 1'b1;
          tick();
          load_abort = 1'b0;
        end
        break;
      end
      rdy        = w1_ready;
      load_valid = ($urandom_range(99) >= gap_pct);
      load_bit   = (accepted < NBITS) ? img[accepted / WIDTH][accepted % WIDTH] : 1'b1;
      load_start = (ncyc % 97 == 50);
      tick();
      ncyc++;
      if (rdy && load_valid) accepted++;
      if (w1_done) dc1 = ncyc + 1;
      if (w0_done) dc0 = ncyc + 1;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] e1, e0, d;
    rst_n = 1'b0;
    repeat (3) tick();
    if ({w1_st, w0_st, w1_rd, w0_rd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got st %h/%h rd %h/%h want all 0", w1_st, w0_st, w1_rd, w0_rd);
    end
    checks++;
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < DEPTH; a += 3) begin
      d = 32'hA5A50000 | a;
      cpu_cycle(a, 1'b1, d, 1'b1);
      e1 = q_snp.pop_front();
      e0 = q_msb.pop_front();
      if ({w1_rd, w0_rd} !== {e1, e0}) begin
        errors++;
        $display("FAIL reset_prefill_rd a=%0d: got %h/%h want %h/%h", a, w1_rd, w0_rd, e1, e0);
      end
      checks++;
    end
    cpu_addr = 5'd3;
    tick();
    #2 rst_n = 1'b0;
    #1;
    if ({w1_st, w0_st, w1_rd, w0_rd} !== '0) begin
      errors++;
      $display("FAIL reset_pulse_async: got st %h/%h rd %h/%h want all 0", w1_st, w0_st, w1_rd, w0_rd);
    end
    checks++;
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      m_snp[a] = '0;
      m_msb[a] = '0;
    end
  endtask

  task automatic test_store_contents(input string name);
    logic [WIDTH-1:0] e1, e0;
    for (int a = 0; a < DEPTH; a++) begin
      cpu_cycle(a, 1'b0, '0, 1'b0);
      e1 = q_snp.pop_front();
      e0 = q_msb.pop_front();
      if ({w1_rd, w0_rd} !== {e1, e0}) begin
        errors++;
        $display("FAIL %s a=%0d: got %h/%h want %h/%h", name, a, w1_rd, w0_rd, e1, e0);
      end
      checks++;
    end
  endtask

  task automatic test_cpu_port();
    logic [WIDTH-1:0] e1, e0;
    cpu_cycle(5, 1'b1, 32'hDEADBEEF, 1'b1);
    void'(q_snp.pop_front());
    void'(q_msb.pop_front());
    cpu_cycle(5, 1'b0, '0, 1'b0);
    void'(q_snp.pop_front());
    void'(q_msb.pop_front());
    if ({w1_rd, w0_rd} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL cpu_write_read: got %h/%h want DEADBEEF", w1_rd, w0_rd);
    end
    checks++;
    cpu_cycle(5, 1'b1, 32'h12345678, 1'b1);
    void'(q_snp.pop_front());
    void'(q_msb.pop_front());
    if ({w1_rd, w0_rd} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL cpu_read_before_write: got %h/%h want DEADBEEF", w1_rd, w0_rd);
    end
    checks++;
    cpu_cycle(5, 1'b0, '0, 1'b0);
    void'(q_snp.pop_front());
    void'(q_msb.pop_front());
    if ({w1_rd, w0_rd} !== {32'h12345678, 32'h12345678}) begin
      errors++;
      $display("FAIL cpu_rbw_new_value: got %h/%h want 12345678", w1_rd, w0_rd);
    end
    checks++;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    st_exp = {1'b1, 1'b1, 1'b0, 6'd0};
    if ({w1_st, w0_st} !== {st_exp, st_exp}) begin
      errors++;
      $display("FAIL cpu_busy_status: got %h/%h want %h", w1_st, w0_st, st_exp);
    end
    checks++;
    cpu_cycle(7, 1'b1, 32'hCAFEF00D, 1'b0);
    e1 = q_snp.pop_front();
    e0 = q_msb.pop_front();
    if ({w1_rd, w0_rd} !== {e1, e0}) begin
      errors++;
      $display("FAIL cpu_read_while_busy: got %h/%h want %h/%h", w1_rd, w0_rd, e1, e0);
    end
    checks++;
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    st_exp = '0;
    if ({w1_st, w0_st} !== {st_exp, st_exp}) begin
      errors++;
      $display("FAIL cpu_abort_idle: got %h/%h want %h", w1_st, w0_st, st_exp);
    end
    checks++;
  endtask

  task automatic test_full_load(input string name);
    int dc1, dc0;
    for (int w = 0; w < DEPTH; w++) img[w] = $urandom;
    img[1] = 32'hFC3F47D9;   // serial 1001101111100010 1111110000111111, first bit in bit 0
    stream_load(0, -1, 1'b0, dc1, dc0);
    if (dc1 != 1057 || dc0 != 1057) begin
      errors++;
      $display("FAIL %s_done_cycle: got t0+%0d/t0+%0d want t0+1057", name, dc1, dc0);
    end
    checks++;
    st_exp = {1'b1, 1'b0, 1'b1, 6'd32};
    if ({w1_st, w0_st} !== {st_exp, st_exp}) begin
      errors++;
      $display("FAIL %s_done_status: got %h/%h want %h", name, w1_st, w0_st, st_exp);
    end
    checks++;
    tick();
    st_exp = {1'b0, 1'b0, 1'b0, 6'd32};
    if ({w1_st, w0_st} !== {st_exp, st_exp}) begin
      errors++;
      $display("FAIL %s_idle_status: got %h/%h want %h", name, w1_st, w0_st, st_exp);
    end
    checks++;
    for (int w = 0; w < DEPTH; w++) begin
      m_snp[w] = img[w];
      m_msb[w] = bitrev(img[w]);
    end
    cpu_cycle(1, 1'b0, '0, 1'b0);
    void'(q_snp.pop_front());
    void'(q_msb.pop_front());
    if ({w1_rd, w0_rd} !== {32'hFC3F47D9, 32'h9BE2FC3F}) begin
      errors++;
      $display("FAIL %s_word1: got %h/%h want FC3F47D9/9BE2FC3F", name, w1_rd, w0_rd);
    end
    checks++;
  endtask

  task automatic test_abort_with_gaps();
    int  dc1, dc0;
    bit  seen_done;
    for (int w = 0; w < DEPTH; w++) img[w] = $urandom;
    img[2] = ~m_snp[2];
    stream_load(30, 2 * WIDTH + 5, 1'b1, dc1, dc0);
    seen_done = (dc1 >= 0) || (dc0 >= 0);
    for (int i = 0; i < 4; i++) begin
      if (w1_done || w0_done) seen_done = 1'b1;
      tick();
    end
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got load_done seen=%0d want 0", seen_done);
    end
    checks++;
    st_exp = {1'b0, 1'b0, 1'b0, 6'd2};
    if ({w1_st, w0_st} !== {st_exp, st_exp}) begin
      errors++;
      $display("FAIL abort_status: got %h/%h want %h", w1_st, w0_st, st_exp);
    end
    checks++;
    for (int w = 0; w < 2; w++) begin
      m_snp[w] = img[w];
      m_msb[w] = bitrev(img[w]);
    end
  endtask

  task automatic test_reset_mid_load();
    int dc1, dc0;
    for (int w = 0; w < DEPTH; w++) img[w] = $urandom | 32'h1;
    stream_load(0, 10 * WIDTH + 3, 1'b0, dc1, dc0);
    #2 rst_n = 1'b0;
    #1;
    if ({w1_st, w0_st, w1_rd, w0_rd} !== '0) begin
      errors++;
      $display("FAIL midload_reset_async: got st %h/%h rd %h/%h want all 0", w1_st, w0_st, w1_rd, w0_rd);
    end
    checks++;
    tick();
    rst_n = 1'b1;
    tick();
    if ({w1_busy, w0_busy} !== 2'b00) begin
      errors++;
      $display("FAIL midload_reset_idle: got busy %b%b want 00", w1_busy, w0_busy);
    end
    checks++;
    for (int a = 0; a < DEPTH; a++) begin
      m_snp[a] = '0;
      m_msb[a] = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      m_snp[a] = '0;
      m_msb[a] = '0;
    end
    test_reset();
    test_store_contents("after_reset");
    test_cpu_port();
    test_store_contents("after_cpu");
    test_full_load("load1");
    test_store_contents("after_load1");
    test_abort_with_gaps();
    test_store_contents("after_abort");
    test_reset_mid_load();
    test_store_contents("after_midload_reset");
    test_full_load("load2");
    test_store_contents("after_load2");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
